i2s_tx_dsp_channel: RTL
=======================

# i2s_tx_dsp_channel

DSP-mode (TDM/short frame-sync) I2S transmitter: the transmit counterpart of the DSP-mode receive channel. It takes 32-bit words from the uDMA TX FIFO over a valid/ready handshake and serialises them onto one or two data lines. Frames are aligned to a frame-sync pulse on `ws_i`, with DSP-A, DSP-B or programmable-offset start. It sits in the I2S TX/RX wrapper beside the standard I2S master TX channel, in the master bit-clock domain.

## Interface
Parameters: none.

Ports:
- `sck_i` in 1: bit clock; the only clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `ws_i` in 1: frame sync.
- `i2s_ch0_o` out 1: serial data, channel 0.
- `i2s_ch1_o` out 1: serial data, channel 1.
- `fifo_data_i` in 32: TX word.
- `fifo_data_valid_i` in 1: word valid.
- `fifo_data_ready_o` out 1: word accepted when valid and ready are both high.
- `fifo_err_o` out 1: one-cycle error pulse (underrun or resync).
- `cfg_en_i` in 1: channel enable.
- `cfg_2ch_i` in 1: drive both data lines.
- `cfg_num_bits_i` in 5: bits per word minus 1.
- `cfg_num_word_i` in 3: words per frame minus 1.
- `cfg_lsb_first_i` in 1: 1 = LSB first, 0 = MSB first.
- `cfg_dsp_mode_i` in 2: 0 = DSP-A, 1 = DSP-B, 2 = offset, 3 = reserved (behaves as 0).
- `cfg_dsp_offset_i` in 5: start offset in mode 2.

## Operation
- Frame start (FS): `ws_i`=1 and `ws_q`=0, where `ws_q` is `ws_i` registered. `ws_q` resets to 1, so a sync line held high out of reset is not a frame start.
- Start delay D is fixed at FS: 1 in mode 0/3, 0 in mode 1, `cfg_dsp_offset_i` in mode 2.
- Config latch: all `cfg_*` except `cfg_en_i` are latched at FS. Changes mid-frame take effect at the next FS.
- FSM states: IDLE, WAIT_FS, DELAY, SHIFT, GAP.
  - IDLE → WAIT_FS when `cfg_en_i`=1.
  - WAIT_FS → DELAY on FS if D>0, otherwise → SHIFT.
  - DELAY → SHIFT after D cycles.
  - SHIFT → GAP after (num_word+1)·(num_bits+1) bits.
  - GAP → DELAY/SHIFT on FS.
  - Any state → IDLE on the cycle after `cfg_en_i`=0. This clears the holding registers; buffered data is dropped.
- Holding registers: ch0 always; ch1 only when `cfg_2ch_i`=1.
  - Fill order is ch0 then ch1.
  - `fifo_data_ready_o` = `cfg_en_i` & (next slot empty, or being loaded into the shifter this cycle). It never depends on `fifo_data_valid_i`.
- Word boundary (first bit of each word): the shifter loads from the holding register(s), which are freed in the same cycle.
  - If any required holding register is empty: that word is all zeros on every active line, `fifo_err_o` pulses, and nothing is consumed.
- Bit order:
  - MSB-first sends bit `num_bits` down to bit 0.
  - LSB-first sends bit 0 up to bit `num_bits`.
  - Bits above `num_bits` are ignored.
- Words are sent back to back with no gap between slots.
- Idle level: outputs are 0 outside SHIFT. `i2s_ch1_o` stays 0 when `cfg_2ch_i`=0.
- FS during DELAY or SHIFT (resync):
  - The current word is discarded and `fifo_err_o` pulses.
  - Word and bit counters restart from the new FS with the new D.
  - The next word is taken from the holding register.

## Timing
- Reset values: `i2s_ch0_o`=0, `i2s_ch1_o`=0, `fifo_data_ready_o`=0, `fifo_err_o`=0, FSM=IDLE, all counters 0.
- Outputs are registered.
- With FS sampled in cycle F, the first data bit is on the output in cycle F+D+1. Each further bit follows one cycle later.
- Mode 2 with offset 0 is identical to mode 1. Offset 31 gives first bit at F+32.
- Minimum word length of 1 bit (`num_bits`=0) sustains one FIFO word per cycle (single channel). Two-channel mode needs 2 words per slot, so `num_bits`≥1 is required to avoid underrun.
- Counters: bit counter 5 bits and word counter 3 bits, both compared against the latched config. Delay counter is 5 bits. No wrap-around beyond these limits.
- `fifo_err_o` is high for exactly one cycle per event. Underrun and resync in the same cycle give a single pulse.

## Configuration
- `I2S_TX_DSP_ERR_CNT_EN` defined adds two ports:
  - `err_cnt_o` out 16: saturating count of `fifo_err_o` pulses. Resets to 0 and holds at 16'hFFFF.
  - `err_cnt_clr_i` in 1: clears the count next cycle. Clear wins over a simultaneous increment.
- `I2S_TX_DSP_ERR_CNT_EN` undefined: neither port exists and there is no counter logic.

## Test plan
- **DSP-A single channel:** mode 0, 16 bits, 2 words, MSB-first, FIFO words 0xA5A5 and 0x1234, FS at cycle 10 → ch0 shows A5A5 then 1234 in cycles 12–43, 0 afterwards, `fifo_err_o` never pulses.
- **Offset mode, LSB-first:** mode 2, offset 5, 8 bits, LSB-first, word 0x01 → ch0=1 at cycle F+6, then seven zeros.
- **Two-channel:** `cfg_2ch_i`=1, 8 bits, 1 word, words 0xF0 then 0x0F → ch0=F0 and ch1=0F in the same cycles, two handshakes per frame.
- **Underrun:** FIFO valid low at the second word boundary → that word is all zeros, `fifo_err_o` pulses once at the boundary cycle, and the next FIFO word goes to the next slot.
- **Resync and disable:** FS mid-word → `fifo_err_o` pulse and restart aligned to the new FS. Then `cfg_en_i`=0 → outputs 0 and ready 0 next cycle. Then `rst_i` mid-frame → all outputs 0 next cycle.

Source files
------------

// File: rtl/i2s_tx_dsp_channel.sv
// i2s_tx_dsp_channel: DSP-mode (short frame-sync) I2S transmitter feeding one or two data lines
//   sck_i, rst_i          bit clock, synchronous active-high reset
//   ws_i                  frame sync; a rising level starts a frame
//   i2s_ch0_o/i2s_ch1_o   registered serial data, 0 outside the data slots
//   fifo_data_i/_valid_i  TX words from the uDMA FIFO; fifo_data_ready_o accepts them
//   fifo_err_o            one-cycle pulse on underrun or resync
//   cfg_*                 enable, two-line mode, word/frame shape, bit order, start mode/offset
//   I2S_TX_DSP_ERR_CNT_EN adds err_cnt_o (saturating error count) and err_cnt_clr_i
module i2s_tx_dsp_channel (
    input  logic        sck_i,
    input  logic        rst_i,
`ifdef I2S_TX_DSP_ERR_CNT_EN
    output logic [15:0] err_cnt_o,
    input  logic        err_cnt_clr_i,
`endif
    input  logic        ws_i,
    output logic        i2s_ch0_o,
    output logic        i2s_ch1_o,
    input  logic [31:0] fifo_data_i,
    input  logic        fifo_data_valid_i,
    output logic        fifo_data_ready_o,
    output logic        fifo_err_o,
    input  logic        cfg_en_i,
    input  logic        cfg_2ch_i,
    input  logic [4:0]  cfg_num_bits_i,
    input  logic [2:0]  cfg_num_word_i,
    input  logic        cfg_lsb_first_i,
    input  logic [1:0]  cfg_dsp_mode_i,
    input  logic [4:0]  cfg_dsp_offset_i
);
    typedef enum logic [2:0] {IDLE, WAIT_FS, DELAY, SHIFT, GAP} state_t;
    state_t      state;
    logic        ws_q, lsb_q, two_q, hold0_v, hold1_v;
    logic [4:0]  bit_cnt, dly_cnt, nb_q;
    logic [2:0]  word_cnt, nw_q;
    logic [31:0] hold0, hold1, word0, word1, new0, new1;
    logic        fs, start, resync, boundary, have, load, err, keep0, keep1, acc, two_l, lsb_l;
    logic [4:0]  d_new, nb_l, first_idx, next_cnt, next_idx;
    always_comb begin
        fs        = ws_i & ~ws_q;
        start     = fs & (state != IDLE);
        resync    = fs & (state == DELAY || state == SHIFT);
        d_new     = cfg_dsp_mode_i == 2'd2 ? cfg_dsp_offset_i : {4'd0, cfg_dsp_mode_i != 2'd1};
        // at a frame start the new config governs the first word immediately
        nb_l      = start ? cfg_num_bits_i : nb_q;
        two_l     = start ? cfg_2ch_i : two_q;
        lsb_l     = start ? cfg_lsb_first_i : lsb_q;
        boundary  = cfg_en_i & (start ? d_new == 5'd0 :
                    (state == DELAY && dly_cnt == 5'd0) ||
                    (state == SHIFT && bit_cnt == nb_q && word_cnt != nw_q));
        have      = hold0_v & (~two_l | hold1_v);
        load      = boundary & have;
        err       = cfg_en_i & (resync | (boundary & ~have));
        keep0     = hold0_v & ~load;
        keep1     = hold1_v & ~(load & two_l);
        fifo_data_ready_o = cfg_en_i & (state != IDLE) & (~keep0 | (cfg_2ch_i & ~keep1));
        acc       = fifo_data_ready_o & fifo_data_valid_i;
        new0      = load ? hold0 : 32'd0;
        new1      = (load & two_l) ? hold1 : 32'd0;
        first_idx = lsb_l ? 5'd0 : nb_l;
        next_cnt  = bit_cnt + 5'd1;
        next_idx  = lsb_q ? next_cnt : nb_q - next_cnt;
    end
    always_ff @(posedge sck_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ws_q       <= 1'b1;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            dly_cnt    <= '0;
            nb_q       <= '0;
            nw_q       <= '0;
            lsb_q      <= 1'b0;
            two_q      <= 1'b0;
            hold0      <= '0;
            hold1      <= '0;
            hold0_v    <= 1'b0;
            hold1_v    <= 1'b0;
            word0      <= '0;
            word1      <= '0;
            i2s_ch0_o  <= 1'b0;
            i2s_ch1_o  <= 1'b0;
            fifo_err_o <= 1'b0;
        end else begin
            ws_q       <= ws_i;
            fifo_err_o <= err;
            i2s_ch0_o  <= 1'b0;
            i2s_ch1_o  <= 1'b0;
            if (!cfg_en_i) begin
                state    <= IDLE;
                hold0_v  <= 1'b0;
                hold1_v  <= 1'b0;
                bit_cnt  <= '0;
                word_cnt <= '0;
                dly_cnt  <= '0;
            end else begin
                // a word arriving while ch0 is still occupied goes to ch1
                hold0_v <= keep0 | acc;
                hold1_v <= keep1 | (acc & keep0);
                if (acc & ~keep0) hold0 <= fifo_data_i;
                if (acc & keep0) hold1 <= fifo_data_i;
                if (start) begin
                    nb_q  <= cfg_num_bits_i;
                    nw_q  <= cfg_num_word_i;
                    lsb_q <= cfg_lsb_first_i;
                    two_q <= cfg_2ch_i;
                end
                if (boundary) begin
                    word0     <= new0;
                    word1     <= new1;
                    i2s_ch0_o <= new0[first_idx];
                    i2s_ch1_o <= new1[first_idx];
                end
                if (state == IDLE) begin
                    state <= WAIT_FS;
                end else if (start) begin
                    bit_cnt  <= '0;
                    word_cnt <= '0;
                    dly_cnt  <= d_new == 5'd0 ? 5'd0 : d_new - 5'd1;
                    state    <= d_new == 5'd0 ? SHIFT : DELAY;
                end else if (state == DELAY) begin
                    if (dly_cnt == 5'd0) state <= SHIFT;
                    else dly_cnt <= dly_cnt - 5'd1;
                end else if (state == SHIFT) begin
                    if (bit_cnt != nb_q) begin
                        bit_cnt   <= next_cnt;
                        i2s_ch0_o <= word0[next_idx];
                        i2s_ch1_o <= two_q & word1[next_idx];
                    end else if (word_cnt != nw_q) begin
                        bit_cnt  <= '0;
                        word_cnt <= word_cnt + 3'd1;
                    end else begin
                        state <= GAP;
                    end
                end
            end
        end
    end
`ifdef I2S_TX_DSP_ERR_CNT_EN
    always_ff @(posedge sck_i) begin
        if (rst_i || err_cnt_clr_i) err_cnt_o <= '0;
        else if (err && err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
    end
`endif
endmodule
